// File: rtl/wb_merge.sv
// Writeback merge: per-thread arbitration of ALU0/ALU1/LSU results onto registered
// register-file write/forward lanes. Define WB_X0_FILTER_EN to acknowledge rd==0 results without writing.
module wb_merge #(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alu_valid,
  input  logic [TID_W-1:0] alu_tid   [1:0],
  input  logic [4:0]       alu_rd    [1:0],
  input  logic [31:0]      alu_data  [1:0],
  output logic [1:0]       alu_ready,
  input  logic             lsu_valid,
  input  logic [TID_W-1:0] lsu_tid,
  input  logic [4:0]       lsu_rd,
  input  logic [31:0]      lsu_data,
  output logic             lsu_ready,
  output logic [NUM_THREADS-1:0] rd_wen,
  output logic [4:0]       rd_forward_addr [NUM_THREADS-1:0],
  output logic [31:0]      rd_forward_data [NUM_THREADS-1:0]
);

  // One-hot thread decode per source; an all-zero vector means an out-of-range tid.
  logic [NUM_THREADS-1:0] alu_match [1:0];
  logic [NUM_THREADS-1:0] lsu_match;

  logic [1:0] alu_x0;
  logic [1:0] alu_arb;
  logic       lsu_x0;
  logic       lsu_arb;

  logic [NUM_THREADS-1:0] lsu_win;
  logic [NUM_THREADS-1:0] alu0_win;
  logic [NUM_THREADS-1:0] alu1_win;
  logic [NUM_THREADS-1:0] contested;

  logic        rr_ptr_reg [NUM_THREADS];
  logic        wen_reg    [NUM_THREADS];
  logic [4:0]  addr_reg   [NUM_THREADS];
  logic [31:0] data_reg   [NUM_THREADS];

  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_match
      assign alu_match[0][gi] = (alu_tid[0] == TID_W'(gi));
      assign alu_match[1][gi] = (alu_tid[1] == TID_W'(gi));
      assign lsu_match[gi]    = (lsu_tid == TID_W'(gi));
    end
  endgenerate

`ifdef WB_X0_FILTER_EN
  // rd==0 results bypass arbitration: acknowledged immediately, never written.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_x0_alu
      assign alu_x0[gi]  = alu_valid[gi] && (|alu_match[gi]) && (alu_rd[gi] == 5'd0);
      assign alu_arb[gi] = alu_valid[gi] && (alu_rd[gi] != 5'd0);
    end
  endgenerate
  assign lsu_x0  = lsu_valid && (|lsu_match) && (lsu_rd == 5'd0);
  assign lsu_arb = lsu_valid && (lsu_rd != 5'd0);
`else
  assign alu_x0  = 2'b00;
  assign alu_arb = alu_valid;
  assign lsu_x0  = 1'b0;
  assign lsu_arb = lsu_valid;
`endif

  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_lane
      logic lsu_hit;
      logic a0_hit;
      logic a1_hit;

      assign lsu_hit = lsu_arb && lsu_match[gi];
      assign a0_hit  = alu_arb[0] && alu_match[0][gi];
      assign a1_hit  = alu_arb[1] && alu_match[1][gi];

      // LSU has absolute priority; the ALUs share the lane by round-robin.
      assign contested[gi] = a0_hit && a1_hit && !lsu_hit;
      assign lsu_win[gi]   = rst && lsu_hit;
      assign alu0_win[gi]  = rst && a0_hit && !lsu_hit && (!a1_hit || !rr_ptr_reg[gi]);
      assign alu1_win[gi]  = rst && a1_hit && !lsu_hit && (!a0_hit || rr_ptr_reg[gi]);

      always_ff @(posedge clk) begin
        if (!rst) begin
          rr_ptr_reg[gi] <= 1'b0;
          wen_reg[gi]    <= 1'b0;
          addr_reg[gi]   <= 5'd0;
          data_reg[gi]   <= 32'd0;
        end else begin
          wen_reg[gi] <= lsu_win[gi] || alu0_win[gi] || alu1_win[gi];
          if (lsu_win[gi]) begin
            addr_reg[gi] <= lsu_rd;
            data_reg[gi] <= lsu_data;
          end else if (alu0_win[gi]) begin
            addr_reg[gi] <= alu_rd[0];
            data_reg[gi] <= alu_data[0];
          end else if (alu1_win[gi]) begin
            addr_reg[gi] <= alu_rd[1];
            data_reg[gi] <= alu_data[1];
          end
          if (contested[gi]) begin
            rr_ptr_reg[gi] <= !rr_ptr_reg[gi];
          end
        end
      end

      assign rd_wen[gi]          = wen_reg[gi];
      assign rd_forward_addr[gi] = addr_reg[gi];
      assign rd_forward_data[gi] = data_reg[gi];
    end
  endgenerate

  assign alu_ready[0] = (|alu0_win) || (rst && alu_x0[0]);
  assign alu_ready[1] = (|alu1_win) || (rst && alu_x0[1]);
  assign lsu_ready    = (|lsu_win)  || (rst && lsu_x0);

  // An out-of-range tid is a source protocol error; such a source is never readied.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!alu_valid[0] || (|alu_match[0]));
      assert (!alu_valid[1] || (|alu_match[1]));
      assert (!lsu_valid || (|lsu_match));
    end
  end

endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: directed vector table for the listed corner cases, then
// randomized sources with hold-until-accepted checked against a thread-level model.
module tb_wb_merge;

`ifdef WB_X0_FILTER_EN
  localparam bit X0F = 1'b1;
`else
  localparam bit X0F = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  alu_valid = 2'b00;
  logic [1:0]  alu_tid  [1:0];
  logic [4:0]  alu_rd   [1:0];
  logic [31:0] alu_data [1:0];
  logic [1:0]  alu_ready;
  logic        lsu_valid = 1'b0;
  logic [1:0]  lsu_tid = 2'd0;
  logic [4:0]  lsu_rd = 5'd0;
  logic [31:0] lsu_data = 32'd0;
  logic        lsu_ready;
  logic [3:0]  rd_wen;
  logic [4:0]  rd_forward_addr [3:0];
  logic [31:0] rd_forward_data [3:0];

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wb_merge #(.NUM_THREADS(4), .TID_W(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_tid(alu_tid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_tid(lsu_tid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_ready(lsu_ready),
    .rd_wen(rd_wen), .rd_forward_addr(rd_forward_addr), .rd_forward_data(rd_forward_data)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  av;
    logic [1:0]  t0, t1;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;
    logic        lv;
    logic [1:0]  lt;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic [1:0]  e_ar;
    logic        e_lr;
    logic [3:0]  e_wen;
    logic [19:0] e_addr;
    logic [127:0] e_data;
  } vec_t;

  function automatic vec_t mk(
      input logic r, input logic [1:0] av,
      input logic [1:0] t0, input logic [4:0] r0, input logic [31:0] d0,
      input logic [1:0] t1, input logic [4:0] r1, input logic [31:0] d1,
      input logic lv, input logic [1:0] lt, input logic [4:0] lr, input logic [31:0] ld,
      input logic [1:0] ear, input logic elr, input logic [3:0] ewen,
      input logic [4:0] a3, input logic [4:0] a2, input logic [4:0] a1, input logic [4:0] a0,
      input logic [31:0] q3, input logic [31:0] q2, input logic [31:0] q1, input logic [31:0] q0);
    vec_t v;
    v.rst = r; v.av = av;
    v.t0 = t0; v.r0 = r0; v.d0 = d0;
    v.t1 = t1; v.r1 = r1; v.d1 = d1;
    v.lv = lv; v.lt = lt; v.lr = lr; v.ld = ld;
    v.e_ar = ear; v.e_lr = elr; v.e_wen = ewen;
    v.e_addr = {a3, a2, a1, a0};
    v.e_data = {q3, q2, q1, q0};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] dut_addr();
    logic [19:0] v;
    for (int t = 0; t < 4; t++) v[t*5 +: 5] = rd_forward_addr[t];
    return v;
  endfunction

  function automatic logic [127:0] dut_data();
    logic [127:0] v;
    for (int t = 0; t < 4; t++) v[t*32 +: 32] = rd_forward_data[t];
    return v;
  endfunction

  // Behavioural model state (per-thread round-robin bit and lane contents).
  bit          m_rr   [4];
  logic [4:0]  m_addr [4];
  logic [31:0] m_data [4];
  logic [3:0]  m_wen;
  logic [1:0]  m_ar;
  logic        m_lr;

  task automatic model_step();
    m_ar = 2'b00;
    m_lr = 1'b0;
    m_wen = 4'b0000;
    if (!rst) begin
      for (int t = 0; t < 4; t++) begin
        m_rr[t] = 0; m_addr[t] = 5'd0; m_data[t] = 32'd0;
      end
      return;
    end
    if (X0F) begin
      if (alu_valid[0] && alu_rd[0] == 5'd0) m_ar[0] = 1'b1;
      if (alu_valid[1] && alu_rd[1] == 5'd0) m_ar[1] = 1'b1;
      if (lsu_valid && lsu_rd == 5'd0) m_lr = 1'b1;
    end
    for (int t = 0; t < 4; t++) begin
      bit lc, c0, c1;
      int w;
      lc = lsu_valid && lsu_tid == t && !(X0F && lsu_rd == 5'd0);
      c0 = alu_valid[0] && alu_tid[0] == t && !(X0F && alu_rd[0] == 5'd0);
      c1 = alu_valid[1] && alu_tid[1] == t && !(X0F && alu_rd[1] == 5'd0);
      if (lc) begin
        m_lr = 1'b1; m_wen[t] = 1'b1; m_addr[t] = lsu_rd; m_data[t] = lsu_data;
      end else if (c0 || c1) begin
        if (c0 && c1) begin
          w = m_rr[t] ? 1 : 0;
          m_rr[t] = !m_rr[t];
        end else begin
          w = c0 ? 0 : 1;
        end
        m_ar[w] = 1'b1; m_wen[t] = 1'b1; m_addr[t] = alu_rd[w]; m_data[t] = alu_data[w];
      end
    end
  endtask

  vec_t vecs [13];

  initial begin
    alu_tid[0] = 2'd0; alu_tid[1] = 2'd0;
    alu_rd[0] = 5'd0; alu_rd[1] = 5'd0;
    alu_data[0] = 32'd0; alu_data[1] = 32'd0;

    // reset with everything valid, then disjoint threads
    vecs[0]  = mk(0, 2'b11, 0, 5, 'h11, 1, 6, 'h22, 1, 2, 7, 'h33, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 2'b11, 0, 5, 'h11, 1, 6, 'h22, 1, 2, 7, 'h33, 2'b11, 1, 4'b0111, 0, 7, 6, 5, 0, 'h33, 'h22, 'h11);
    // ALU collision on tid 3 for four cycles
    vecs[2]  = mk(1, 2'b11, 3, 1, 'hA, 3, 2, 'hB, 0, 0, 0, 0, 2'b01, 0, 4'b1000, 1, 7, 6, 5, 'hA, 'h33, 'h22, 'h11);
    vecs[3]  = mk(1, 2'b11, 3, 1, 'hA, 3, 2, 'hB, 0, 0, 0, 0, 2'b10, 0, 4'b1000, 2, 7, 6, 5, 'hB, 'h33, 'h22, 'h11);
    vecs[4]  = mk(1, 2'b11, 3, 1, 'hA, 3, 2, 'hB, 0, 0, 0, 0, 2'b01, 0, 4'b1000, 1, 7, 6, 5, 'hA, 'h33, 'h22, 'h11);
    vecs[5]  = mk(1, 2'b11, 3, 1, 'hA, 3, 2, 'hB, 0, 0, 0, 0, 2'b10, 0, 4'b1000, 2, 7, 6, 5, 'hB, 'h33, 'h22, 'h11);
    // LSU priority on tid 1, then ALU0 wins the contest
    vecs[6]  = mk(1, 2'b11, 1, 4, 'hD, 1, 5, 'hE, 1, 1, 3, 'hC, 2'b00, 1, 4'b0010, 2, 7, 3, 5, 'hB, 'h33, 'hC, 'h11);
    vecs[7]  = mk(1, 2'b11, 1, 4, 'hD, 1, 5, 'hE, 1, 1, 3, 'hC, 2'b00, 1, 4'b0010, 2, 7, 3, 5, 'hB, 'h33, 'hC, 'h11);
    vecs[8]  = mk(1, 2'b11, 1, 4, 'hD, 1, 5, 'hE, 0, 0, 0, 0, 2'b01, 0, 4'b0010, 2, 7, 4, 5, 'hB, 'h33, 'hD, 'h11);
    // reset mid-stream; rr_ptr[1] was 1, must be back to 0 afterwards
    vecs[9]  = mk(0, 2'b01, 0, 9, 'hFF, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 2'b11, 1, 4, 'hD, 1, 5, 'hE, 0, 0, 0, 0, 2'b01, 0, 4'b0010, 0, 0, 4, 0, 0, 0, 'hD, 0);
`ifdef WB_X0_FILTER_EN
    vecs[11] = mk(1, 2'b11, 2, 0, 'h77, 2, 4, 'h55, 0, 0, 0, 0, 2'b11, 0, 4'b0100, 0, 4, 4, 0, 0, 'h55, 'hD, 0);
    vecs[12] = mk(1, 2'b00, 2, 0, 'h77, 2, 4, 'h55, 0, 0, 0, 0, 2'b00, 0, 4'b0000, 0, 4, 4, 0, 0, 'h55, 'hD, 0);
`else
    vecs[11] = mk(1, 2'b11, 2, 0, 'h77, 2, 4, 'h55, 0, 0, 0, 0, 2'b01, 0, 4'b0100, 0, 0, 4, 0, 0, 'h77, 'hD, 0);
    vecs[12] = mk(1, 2'b10, 2, 0, 'h77, 2, 4, 'h55, 0, 0, 0, 0, 2'b10, 0, 4'b0100, 0, 4, 4, 0, 0, 'h55, 'hD, 0);
`endif

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; alu_valid = vecs[i].av;
      alu_tid[0] = vecs[i].t0; alu_rd[0] = vecs[i].r0; alu_data[0] = vecs[i].d0;
      alu_tid[1] = vecs[i].t1; alu_rd[1] = vecs[i].r1; alu_data[1] = vecs[i].d1;
      lsu_valid = vecs[i].lv; lsu_tid = vecs[i].lt; lsu_rd = vecs[i].lr; lsu_data = vecs[i].ld;
      #1;
      $display("[TB] vec %0d rst=%0b alu_ready=%b lsu_ready=%b", i, rst, alu_ready, lsu_ready);
      chk($sformatf("vec%0d alu_ready", i), 128'(alu_ready), 128'(vecs[i].e_ar));
      chk($sformatf("vec%0d lsu_ready", i), 128'(lsu_ready), 128'(vecs[i].e_lr));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d rd_wen", i), 128'(rd_wen), 128'(vecs[i].e_wen));
      chk($sformatf("vec%0d addr", i), 128'(dut_addr()), 128'(vecs[i].e_addr));
      chk($sformatf("vec%0d data", i), dut_data(), vecs[i].e_data);
    end

    // Random phase: start from a clean reset so the model state is known.
    rst = 1'b0; alu_valid = 2'b00; lsu_valid = 1'b0;
    #1;
    model_step();
    @(posedge clk);
    #1;
    begin
      logic [1:0] acc_a;
      logic       acc_l;
      acc_a = 2'b11;
      acc_l = 1'b1;
      for (int c = 0; c < 800; c++) begin
        rst = ($urandom_range(0, 99) >= 3);
        for (int s = 0; s < 2; s++) begin
          if (!alu_valid[s] || acc_a[s]) begin
            alu_valid[s] = ($urandom_range(0, 99) < 65);
            alu_tid[s]   = 2'($urandom_range(0, 3));
            alu_rd[s]    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data[s]  = $urandom;
          end
        end
        if (!lsu_valid || acc_l) begin
          lsu_valid = ($urandom_range(0, 99) < 40);
          lsu_tid   = 2'($urandom_range(0, 3));
          lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          lsu_data  = $urandom;
        end
        #1;
        model_step();
        $display("[TB] rnd %0d rst=%0b av=%b lv=%b ready=%b%b", c, rst, alu_valid, lsu_valid, lsu_ready, alu_ready);
        chk($sformatf("rnd%0d ready", c), 128'({lsu_ready, alu_ready}), 128'({m_lr, m_ar}));
        @(posedge clk);
        #1;
        chk($sformatf("rnd%0d rd_wen", c), 128'(rd_wen), 128'(m_wen));
        chk($sformatf("rnd%0d addr", c), 128'(dut_addr()),
            128'({m_addr[3], m_addr[2], m_addr[1], m_addr[0]}));
        chk($sformatf("rnd%0d data", c), dut_data(), {m_data[3], m_data[2], m_data[1], m_data[0]});
        acc_a = m_ar & alu_valid;
        acc_l = m_lr & lsu_valid;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
